perceptron_core: RTL and testbench

Parametrised single-neuron perceptron engine that generalises the fixed accumulator/mux/serial datapath into one byte-command-driven block. It sits between the UART receiver/transmitter and the status LEDs. It holds N signed 8-bit weights, a bias and an input vector, and computes a signed multiply-accumulate sequentially. It returns the accumulator as bytes and can optionally apply the perceptron learning rule.

---
 rtl/perceptron_core.sv | 212 +++++++++++++++++++++
 tb/tb_perceptron_core.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_core.sv
`default_nettype none
// ============================================================================
// perceptron_core : byte-command single-neuron multiply-accumulate engine
// Optional learning-rule command compiled in with PERCEPTRON_LEARN_EN
// Rev 1.0
// ============================================================================
module perceptron_core #(
  parameter int N_INPUTS  = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] data_in,
  input  logic       in,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       out,
  output logic       fire,
  output logic [7:0] status
);

  localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int NBYTES = ACC_WIDTH / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_INPUTS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_LOAD_X  = 3'd3,
    S_MAC     = 3'd4,
    S_SEND    = 3'd5,
    S_LEARN_T = 3'd6,
    S_LEARN   = 3'd7
  } state_t;

  state_t state, state_nx;

  logic [7:0]           w [N_INPUTS];
  logic [7:0]           x [N_INPUTS];
  logic [7:0]           bias;
  logic [ACC_WIDTH-1:0] acc;
  logic [IDX_W-1:0]     idx;
  logic [BYTE_W-1:0]    byte_idx;
  logic                 overrun;

  logic [7:0]           wi, xi, send_byte;
  logic signed [15:0]   prod;
  logic [ACC_WIDTH-1:0] prod_ext, bias_ext, acc_sum;
  logic                 acc_pos, send_go;

  assign wi   = w[idx];
  assign xi   = x[idx];
  // Operands widened to 16 bits so the low half of the product is the exact signed result
  assign prod = $signed({{8{wi[7]}}, wi}) * $signed({{8{xi[7]}}, xi});

  generate
    if (ACC_WIDTH > 16) begin : g_prod_wide
      assign prod_ext = {{(ACC_WIDTH-16){prod[15]}}, prod};
    end else begin : g_prod_narrow
      assign prod_ext = prod;
    end
  endgenerate

  assign bias_ext = {{(ACC_WIDTH-8){bias[7]}}, bias};
  assign acc_sum  = acc + prod_ext;
  assign acc_pos  = !acc_sum[ACC_WIDTH-1] && (acc_sum != '0);
  assign send_go  = (state == S_SEND) && !busy && !out;

  always_comb begin
    send_byte = acc[7:0];
    for (int b = 0; b < NBYTES; b++)
      if (byte_idx == BYTE_W'(b)) send_byte = acc[b*8 +: 8];
  end

`ifdef PERCEPTRON_LEARN_EN
  logic       target;
  logic [8:0] w_upd, b_upd;
  logic [7:0] w_sat, b_sat;

  always_comb begin
    w_upd = target ? ({wi[7], wi} + {xi[7], xi}) : ({wi[7], wi} - {xi[7], xi});
    b_upd = target ? ({bias[7], bias} + 9'd1) : ({bias[7], bias} - 9'd1);
    // Bits 8 and 7 disagree only on overflow past the signed 8-bit range
    w_sat = (w_upd[8] != w_upd[7]) ? (w_upd[8] ? 8'h80 : 8'h7F) : w_upd[7:0];
    b_sat = (b_upd[8] != b_upd[7]) ? (b_upd[8] ? 8'h80 : 8'h7F) : b_upd[7:0];
  end
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (in) begin
          case (data_in)
            8'h01:   state_nx = S_LOAD_W;
            8'h02:   state_nx = S_LOAD_B;
            8'h03:   state_nx = S_LOAD_X;
            8'h04:   state_nx = S_SEND;
`ifdef PERCEPTRON_LEARN_EN
            8'h05:   state_nx = S_LEARN_T;
`endif
            default: state_nx = S_IDLE;
          endcase
        end
      end
      S_LOAD_W: if (in && idx == LAST_IDX) state_nx = S_IDLE;
      S_LOAD_B: if (in) state_nx = S_IDLE;
      S_LOAD_X: if (in && idx == LAST_IDX) state_nx = S_MAC;
      S_MAC:    if (idx == LAST_IDX) state_nx = S_IDLE;
      S_SEND:   if (send_go && byte_idx == LAST_BYTE) state_nx = S_IDLE;
`ifdef PERCEPTRON_LEARN_EN
      S_LEARN_T: if (in) state_nx = (data_in[0] == fire) ? S_IDLE : S_LEARN;
      S_LEARN:   if (idx == LAST_IDX) state_nx = S_IDLE;
`endif
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        w[i] <= '0;
        x[i] <= '0;
      end
      bias     <= '0;
      acc      <= '0;
      idx      <= '0;
      byte_idx <= '0;
      overrun  <= 1'b0;
      fire     <= 1'b0;
      out      <= 1'b0;
      data_out <= '0;
`ifdef PERCEPTRON_LEARN_EN
      target   <= 1'b0;
`endif
    end else begin
      out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in) begin
            idx      <= '0;
            byte_idx <= '0;
            if (data_in == 8'h00) begin
              acc     <= '0;
              fire    <= 1'b0;
              overrun <= 1'b0;
            end
          end
        end
        S_LOAD_W: begin
          if (in) begin
            w[idx] <= data_in;
            idx    <= idx + IDX_W'(1);
          end
        end
        S_LOAD_B: if (in) bias <= data_in;
        S_LOAD_X: begin
          if (in) begin
            x[idx] <= data_in;
            if (idx == LAST_IDX) begin
              idx <= '0;
              acc <= bias_ext;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_MAC: begin
          if (in) overrun <= 1'b1;
          acc <= acc_sum;
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) fire <= acc_pos;
        end
        S_SEND: begin
          if (in) overrun <= 1'b1;
          if (send_go) begin
            out      <= 1'b1;
            data_out <= send_byte;
            byte_idx <= byte_idx + BYTE_W'(1);
          end
        end
`ifdef PERCEPTRON_LEARN_EN
        S_LEARN_T: begin
          if (in) begin
            target <= data_in[0];
            idx    <= '0;
          end
        end
        S_LEARN: begin
          if (in) overrun <= 1'b1;
          w[idx] <= w_sat;
          if (idx == '0) bias <= b_sat;
          idx <= idx + IDX_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  assign status = {fire, (state != S_IDLE), overrun, 2'b00, state};

endmodule
`default_nettype wire

// File: tb/tb_perceptron_core.sv
`default_nettype none
// Bench for perceptron_core: directed and randomized command sequences checked
// against an arithmetic reference model (sum of products modulo 2^ACC_WIDTH).
module tb_perceptron_core;

  localparam int NA = 4,  WA = 24;
  localparam int NB = 64, WB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst_a, nrst_b, in_a, in_b, busy_a, busy_b, busy_hold;
  logic [7:0] data_in, dout_a, dout_b, status_a, status_b;
  logic       out_a, out_b, fire_a, fire_b;
  int         tx_a = 0, tx_b = 0;

  assign busy_a = busy_hold || (tx_a != 0);
  assign busy_b = (tx_b != 0);

  perceptron_core #(.N_INPUTS(NA), .ACC_WIDTH(WA)) dut_a (
    .clk(clk), .nRst(nrst_a), .data_in(data_in), .in(in_a), .busy(busy_a),
    .data_out(dout_a), .out(out_a), .fire(fire_a), .status(status_a)
  );

  perceptron_core #(.N_INPUTS(NB), .ACC_WIDTH(WB)) dut_b (
    .clk(clk), .nRst(nrst_b), .data_in(data_in), .in(in_b), .busy(busy_b),
    .data_out(dout_b), .out(out_b), .fire(fire_b), .status(status_b)
  );

  int n_cmp = 0, n_err = 0;
  int rw [64];
  int rx [64];
  int rb;

  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  int   out_cnt_a = 0, proto_err = 0;
  logic busy_prev_a = 1'b0, out_prev_a = 1'b0;

  // Transmitter stand-in: busy for a few cycles after every transmit strobe
  always @(posedge clk) begin
    if (out_a) tx_a <= 6; else if (tx_a != 0) tx_a <= tx_a - 1;
    if (out_b) tx_b <= 4; else if (tx_b != 0) tx_b <= tx_b - 1;
  end

  always @(negedge clk) begin
    if (out_a) begin
      q_a.push_back(dout_a);
      out_cnt_a <= out_cnt_a + 1;
      if (busy_prev_a || out_prev_a) proto_err <= proto_err + 1;
    end
    if (out_b) q_b.push_back(dout_b);
    busy_prev_a <= busy_a;
    out_prev_a  <= out_a;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] st(input int sel);
    return (sel == 0) ? status_a : status_b;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic logic [7:0] qpop(input int sel);
    if (sel == 0) return q_a.pop_front();
    return q_b.pop_front();
  endfunction

  function automatic int rs8();
    int v;
    v = $urandom_range(0, 255);
    return (v > 127) ? v - 256 : v;
  endfunction

  function automatic longint mac_ref(input int n, input int width);
    longint sum;
    sum = rb;
    for (int i = 0; i < n; i++) sum += longint'(rw[i] * rx[i]);
    return sum & ((longint'(1) << width) - 1);
  endfunction

  function automatic logic fire_ref(input longint v, input int width);
    return (v != 0) && (v < (longint'(1) << (width - 1)));
  endfunction

`ifdef PERCEPTRON_LEARN_EN
  function automatic int sat8(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  task automatic learn_ref(input int n, input int t);
    for (int i = 0; i < n; i++) rw[i] = sat8(t ? rw[i] + rx[i] : rw[i] - rx[i]);
    rb = sat8(t ? rb + 1 : rb - 1);
  endtask
`endif

  task automatic send(input int sel, input logic [7:0] v);
    @(posedge clk); #1;
    data_in = v;
    if (sel == 0) in_a = 1'b1; else in_b = 1'b1;
    @(posedge clk); #1;
    in_a = 1'b0;
    in_b = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    logic [7:0] s;
    int k;
    k = 0;
    s = st(sel);
    while (s[2:0] != 3'd0 && k < 500) begin
      @(posedge clk); #1;
      s = st(sel);
      k++;
    end
    if (s[2:0] != 3'd0) chk("idle_timeout", s[2:0], 0);
  endtask

  task automatic load_w(input int sel, input int n);
    logic [7:0] s;
    send(sel, 8'h01);
    s = st(sel);
    chk("cmd_state_loadw", s[2:0], 1);
    for (int i = 0; i < n; i++) send(sel, 8'(rw[i]));
    send(sel, 8'h02);
    send(sel, 8'(rb));
  endtask

  // mode 0: exact latency check, 1: inject a byte during MAC, 2: reset during MAC
  task automatic run(input int sel, input int n, input int mode);
    logic [7:0] s;
    send(sel, 8'h03);
    for (int i = 0; i < n; i++) send(sel, 8'(rx[i]));
    s = st(sel);
    chk("mac_entry", s[2:0], 4);
    if (mode == 0) begin
      repeat (n - 1) @(posedge clk);
      #1; s = st(sel);
      chk("mac_last_cycle", s[2:0], 4);
      @(posedge clk); #1; s = st(sel);
      chk("mac_done", s[2:0], 0);
    end else if (mode == 1) begin
      send(sel, 8'hAA);
      wait_idle(sel);
    end else begin
      #2 nrst_a = 1'b0;
      #1;
      chk("rst_mid_mac_status", status_a, 0);
      chk("rst_mid_mac_fire", fire_a, 0);
      @(posedge clk); #1;
      nrst_a = 1'b1;
    end
  endtask

  task automatic read_acc(input int sel, input int nbytes, input int hold, output longint val);
    int snap, waited;
    val = 0;
    if (sel == 0) q_a.delete(); else q_b.delete();
    snap = out_cnt_a;
    if (hold > 0) busy_hold = 1'b1;
    send(sel, 8'h04);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk("busy_hold_no_out", out_cnt_a - snap, 0);
      busy_hold = 1'b0;
    end
    waited = 0;
    while (qsize(sel) < nbytes && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (qsize(sel) < nbytes) chk("read_timeout", qsize(sel), nbytes);
    else for (int i = 0; i < nbytes; i++) val |= longint'(qpop(sel)) << (8 * i);
    wait_idle(sel);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint v;
    logic [7:0] s;
    nrst_a = 1'b0; nrst_b = 1'b0;
    in_a = 1'b0; in_b = 1'b0; busy_hold = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", status_a, 8'h00);
    chk("reset_out", out_a, 0);
    chk("reset_dout", dout_a, 0);
    chk("reset_fire", fire_a, 0);
    nrst_a = 1'b1; nrst_b = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_status", status_a, 8'h00);

    // Directed: w = 2,-3,4,1  b = -5  x = 1,1,1,1  -> -1
    rw[0] = 2; rw[1] = -3; rw[2] = 4; rw[3] = 1; rb = -5;
    for (int i = 0; i < NA; i++) rx[i] = 1;
    load_w(0, NA);
    run(0, NA, 0);
    chk("dir_fire", fire_a, 0);
    read_acc(0, 3, 0, v);
    chk("dir_acc", v, 24'hFFFFFF);

    // Unknown command is ignored; READ held off by busy for 100 cycles
    send(0, 8'h7A);
    s = status_a;
    chk("unknown_cmd_state", s[2:0], 0);
    read_acc(0, 3, 100, v);
    chk("read_after_busy", v, mac_ref(NA, WA));

`ifdef PERCEPTRON_LEARN_EN
    send(0, 8'h05);
    s = status_a; chk("learn_t_state", s[2:0], 6);
    send(0, 8'h01);
    s = status_a; chk("learn_state", s[2:0], 7);
    wait_idle(0);
    learn_ref(NA, 1);
    run(0, NA, 0);
    chk("learn_fire", fire_a, 1);
    read_acc(0, 3, 0, v);
    chk("learn_acc", v, 4);
    send(0, 8'h05);
    send(0, 8'h01);
    s = status_a; chk("learn_same_target", s[2:0], 0);
    read_acc(0, 3, 0, v);
    chk("learn_noop_acc", v, 4);
    rw[0] = 127; rw[1] = -128; rw[2] = 0; rw[3] = 0; rb = -128;
    rx[0] = 5; rx[1] = 5; rx[2] = 0; rx[3] = 0;
    load_w(0, NA);
    run(0, NA, 0);
    chk("sat_pre_fire", fire_a, 0);
    send(0, 8'h05);
    send(0, 8'h01);
    wait_idle(0);
    learn_ref(NA, 1);
    run(0, NA, 0);
    read_acc(0, 3, 0, v);
    chk("sat_acc", v, mac_ref(NA, WA));
`else
    send(0, 8'h05);
    s = status_a;
    chk("cmd5_ignored", s[2:0], 0);
`endif

    // Overrun on a byte during MAC; CLEAR resets it but keeps weights
    run(0, NA, 1);
    chk("overrun_set", status_a[5], 1);
    chk("overrun_fire", fire_a, fire_ref(mac_ref(NA, WA), WA));
    send(0, 8'h00);
    chk("clear_overrun", status_a[5], 0);
    chk("clear_fire", fire_a, 0);
    read_acc(0, 3, 0, v);
    chk("clear_acc", v, 0);
    run(0, NA, 0);
    read_acc(0, 3, 0, v);
    chk("retained_acc", v, mac_ref(NA, WA));

    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < NA; i++) begin
        rw[i] = rs8();
        rx[i] = rs8();
      end
      rb = rs8();
      load_w(0, NA);
      run(0, NA, 0);
      chk("rand_fire", fire_a, fire_ref(mac_ref(NA, WA), WA));
      read_acc(0, 3, 0, v);
      chk("rand_acc", v, mac_ref(NA, WA));
    end

    // Asynchronous reset during MAC clears everything
    run(0, NA, 2);
    for (int i = 0; i < NA; i++) begin
      rw[i] = 0;
      rx[i] = 0;
    end
    rb = 0;
    read_acc(0, 3, 0, v);
    chk("acc_after_reset", v, 0);

    // 64 inputs, all 127, 16-bit accumulator wraps negative
    for (int i = 0; i < NB; i++) begin
      rw[i] = 127;
      rx[i] = 127;
    end
    rb = 127;
    load_w(1, NB);
    run(1, NB, 0);
    chk("wide_fire", fire_b, 0);
    read_acc(1, 2, 0, v);
    chk("wide_acc", v, 16'hC0BF);
    chk("wide_acc_model", v, mac_ref(NB, WB));

    chk("out_protocol", proto_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
